// File: rtl/noc_pkg.sv
// Shared types and width helpers for the NoC network-interface injector.
package noc_pkg;

   localparam int FLIT_W      = 16;
   localparam int DEF_CREDITS = 4;

   typedef logic [FLIT_W-1:0] flit_t;

   // Width needed to hold a credit count in the range 0..credits.
   function automatic int credit_w(input int credits);
      return $clog2(credits + 1);
   endfunction

   // Address width of a power-of-two FIFO (pointer carries one extra wrap bit).
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   typedef logic [credit_w(DEF_CREDITS)-1:0] credit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous staging FIFO for outbound flits. Full/empty are told apart by
// an extra wrap bit on each pointer. The head entry is visible combinationally.
module noc_sync_fifo #(
   parameter int FLIT_W     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [FLIT_W-1:0] push_data,
   input  logic              pop,
   output logic [FLIT_W-1:0] head_data,
   output logic              full,
   output logic              empty
);
   import noc_pkg::*;

   localparam int AW = ptr_w(FIFO_DEPTH);

   logic [FLIT_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic              do_push_s;
   logic              do_pop_s;
   logic              full_s;
   logic              empty_s;

   // Full when the indices match but the wrap bits differ; empty when equal.
   always_comb begin
      full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      empty_s   = (wr_ptr_r == rd_ptr_r);
      do_push_s = push && !full_s;
      do_pop_s  = pop && !empty_s;
   end

   assign full      = full_s;
   assign empty     = empty_s;
   assign head_data = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer advance; reset flushes every queued entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Storage write; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/noc_flit_tx.sv
// Credit-based flit injector: stages core flits in a FIFO and forwards them to
// one router input port only while the downstream buffer has free slots.
module noc_flit_tx #(
   parameter int FLIT_W     = 16,
   parameter int CREDITS    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push_i,
   input  logic [FLIT_W-1:0]              push_data_i,
   output logic                           push_ready_o,
   output logic                           valid_o,
   output logic [FLIT_W-1:0]              data_o,
   input  logic                           credit_i,
   output logic [$clog2(CREDITS+1)-1:0]   credit_cnt_o,
   output logic                           credit_err_o
);
   import noc_pkg::*;

   localparam int                CNT_W   = credit_w(CREDITS);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CREDITS);

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [FLIT_W-1:0] head_s;
   logic              send_s;
   logic [CNT_W-1:0]  credit_cnt_r;
   logic [CNT_W-1:0]  credit_cnt_nxt_s;
   logic              credit_err_r;
   logic              credit_err_nxt_s;
   logic              valid_r;
   logic [FLIT_W-1:0] data_r;

   noc_sync_fifo #(
      .FLIT_W     (FLIT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_i),
      .push_data (push_data_i),
      .pop       (send_s),
      .head_data (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // A flit leaves only when one is queued and the router has a free slot.
   always_comb begin
      send_s = !fifo_empty_s && (credit_cnt_r != {CNT_W{1'b0}});
   end

   // Credit bookkeeping: a send consumes a slot, a returned credit frees one;
   // a return with the counter already full is a protocol error and saturates.
   always_comb begin
      credit_cnt_nxt_s = credit_cnt_r;
      credit_err_nxt_s = credit_err_r;
      case ({send_s, credit_i})
         2'b10: begin
            credit_cnt_nxt_s = credit_cnt_r - CNT_W'(1);
         end
         2'b01: begin
            if (credit_cnt_r == CNT_MAX) begin
               credit_err_nxt_s = 1'b1;
            end else begin
               credit_cnt_nxt_s = credit_cnt_r + CNT_W'(1);
            end
         end
         2'b11: begin
            credit_cnt_nxt_s = credit_cnt_r;
         end
         2'b00: begin
            credit_cnt_nxt_s = credit_cnt_r;
         end
         default: begin
            credit_cnt_nxt_s = credit_cnt_r;
            credit_err_nxt_s = credit_err_r;
         end
      endcase
   end

   // Credit counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt_r <= CNT_MAX;
         credit_err_r <= 1'b0;
      end else begin
         credit_cnt_r <= credit_cnt_nxt_s;
         credit_err_r <= credit_err_nxt_s;
      end
   end

   // Output register: one-cycle valid pulse per flit, data held between flits.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {FLIT_W{1'b0}};
      end else begin
         valid_r <= send_s;
         if (send_s) begin
            data_r <= head_s;
         end
      end
   end

   assign push_ready_o = !fifo_full_s;
   assign valid_o      = valid_r;
   assign data_o       = data_r;
   assign credit_cnt_o = credit_cnt_r;
   assign credit_err_o = credit_err_r;

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed bench for noc_flit_tx with a scoreboard of expected flits and the
// cycle each one should appear in (-1 where only ordering matters).
module tb_noc_flit_tx;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push_i = 1'b0;
   logic [15:0] push_data_i = 16'h0000;
   logic        push_ready_o;
   logic        valid_o;
   logic [15:0] data_o;
   logic        credit_i = 1'b0;
   logic [2:0]  credit_cnt_o;
   logic        credit_err_o;

   int    cyc   = 0;
   int    n_vec = 0;
   int    n_err = 0;
   flit_t exp_data_q[$];
   int    exp_cyc_q[$];

   noc_flit_tx #(.FLIT_W(16), .CREDITS(4), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push_i),
      .push_data_i  (push_data_i),
      .push_ready_o (push_ready_o),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .credit_i     (credit_i),
      .credit_cnt_o (credit_cnt_o),
      .credit_err_o (credit_err_o)
   );

   always #5 clk = ~clk;

   // Cycle number: cycle k is the interval after the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && valid_o) begin
         n_vec = n_vec + 1;
         if (exp_data_q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL unexpected_flit: cycle %0d data_o=%h, nothing expected", cyc, data_o);
         end else begin
            flit_t ed;
            int    ec;
            ed = exp_data_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (data_o !== ed || (ec >= 0 && cyc != ec)) begin
               n_err = n_err + 1;
               $display("FAIL flit_out: cycle %0d data_o=%h, expected %h in cycle %0d", cyc, data_o, ed, ec);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_flit(input flit_t d, input int c);
      exp_data_q.push_back(d);
      exp_cyc_q.push_back(c);
   endtask

   task automatic credit_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         credit_i = 1'b1;
         tick();
      end
      credit_i = 1'b0;
   endtask

   initial begin
      int k;
      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_ready", int'(push_ready_o), 1);
      chk("rst_cnt", int'(credit_cnt_o), 4);
      chk("rst_err", int'(credit_err_o), 0);
      rst = 1'b0;
      tick();

      // Single flit: valid exactly two cycles after the push cycle
      k = cyc;
      push_i = 1'b1; push_data_i = 16'hA5A5;
      expect_flit(16'hA5A5, k + 2);
      tick();
      push_i = 1'b0;
      repeat (4) tick();
      chk("single_cnt", int'(credit_cnt_o), 3);
      credit_pulses(1);
      tick();
      chk("single_cnt_back", int'(credit_cnt_o), 4);

      // Credit exhaustion: four back-to-back flits, then stall at zero credits
      k = cyc;
      for (int i = 1; i <= 6; i++) begin
         push_i = 1'b1; push_data_i = 16'(i);
         expect_flit(16'(i), (i <= 4) ? (k + 1 + i) : -1);
         tick();
      end
      push_i = 1'b0;
      repeat (6) tick();
      chk("exhaust_cnt", int'(credit_cnt_o), 0);
      chk("exhaust_valid", int'(valid_o), 0);
      k = cyc;
      exp_cyc_q[0] = k + 2;
      credit_pulses(1);
      repeat (4) tick();
      chk("one_credit_cnt", int'(credit_cnt_o), 0);
      k = cyc;
      exp_cyc_q[0] = k + 2;
      credit_pulses(1);
      repeat (4) tick();
      credit_pulses(4);
      tick();
      chk("refill_cnt", int'(credit_cnt_o), 4);

      // Send and credit return in the same cycle leave the count unchanged
      k = cyc;
      for (int i = 0; i < 3; i++) begin
         push_i = 1'b1; push_data_i = 16'(16'hB001 + i);
         expect_flit(16'(16'hB001 + i), k + 2 + i);
         tick();
      end
      push_i = 1'b0;
      credit_i = 1'b1;
      chk("simul_cnt_before", int'(credit_cnt_o), 2);
      tick();
      credit_i = 1'b0;
      chk("simul_cnt_after", int'(credit_cnt_o), 2);
      repeat (3) tick();
      chk("simul_cnt_settled", int'(credit_cnt_o), 2);

      // Drain the remaining credits, then fill the FIFO past capacity
      k = cyc;
      for (int i = 0; i < 2; i++) begin
         push_i = 1'b1; push_data_i = 16'(16'hC001 + i);
         expect_flit(16'(16'hC001 + i), k + 2 + i);
         tick();
      end
      push_i = 1'b0;
      repeat (4) tick();
      chk("full_pre_cnt", int'(credit_cnt_o), 0);
      for (int i = 0; i < 9; i++) begin
         push_i = 1'b1; push_data_i = 16'(16'hD000 + i);
         chk("full_ready", int'(push_ready_o), (i < 8) ? 1 : 0);
         if (i < 8) expect_flit(16'(16'hD000 + i), -1);
         tick();
      end
      push_i = 1'b0;
      chk("full_ready_held", int'(push_ready_o), 0);
      k = cyc;
      for (int i = 0; i < 8; i++) exp_cyc_q[i] = k + 2 + i;
      credit_pulses(8);
      repeat (4) tick();
      chk("full_ready_after", int'(push_ready_o), 1);
      chk("full_cnt_after", int'(credit_cnt_o), 0);

      // Credit overflow with an empty FIFO is flagged and sticky
      credit_pulses(4);
      tick();
      chk("ovf_pre_cnt", int'(credit_cnt_o), 4);
      credit_pulses(1);
      chk("ovf_err", int'(credit_err_o), 1);
      chk("ovf_cnt", int'(credit_cnt_o), 4);
      repeat (3) tick();
      chk("ovf_err_sticky", int'(credit_err_o), 1);

      // Reset with three flits still queued
      k = cyc;
      for (int i = 0; i < 7; i++) begin
         push_i = 1'b1; push_data_i = 16'(16'hE001 + i);
         if (i < 4) expect_flit(16'(16'hE001 + i), k + 2 + i);
         tick();
      end
      push_i = 1'b0;
      repeat (6) tick();
      chk("midrst_pre_cnt", int'(credit_cnt_o), 0);
      rst = 1'b1;
      tick();
      chk("midrst_valid", int'(valid_o), 0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("midrst_cnt", int'(credit_cnt_o), 4);
      chk("midrst_err", int'(credit_err_o), 0);
      chk("midrst_ready", int'(push_ready_o), 1);
      chk("sb_drained", exp_data_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
